// File: rtl/lsu_mem_bridge_if.sv
// lsu_mem_bridge_if: word-wide data memory bus with request/grant/read-valid handshake.
interface lsu_mem_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: RV32 load/store unit bridging the core memory stage to a word-wide
// data memory, with sub-word formatting, alignment checks and a bounded-latency timeout.
module lsu_mem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    lsu_mem_bridge_if.master  mem
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state, state_nxt;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] cnt;
    logic [31:0] ext;
    logic [31:0] wdata_fmt;
    logic [31:0] rdata_nxt;
    logic [3:0]  be_fmt;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        bad;
    logic        tmo;
    logic        err_nxt;
    logic        accept;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign mem.req    = state == ISSUE;
    always_comb begin
        bad = !(req_funct3 inside {3'd0, 3'd1, 3'd2} || (!req_we && req_funct3 inside {3'd4, 3'd5}))
            || (req_funct3[1:0] == 2'b01 && req_addr[0])
            || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        accept = state == IDLE && req_valid && !bad;
        be_fmt = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0]
               : req_funct3[1:0] == 2'b01 ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
        wdata_fmt = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}}
                  : req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        // lane extraction uses the offset/funct3 latched at accept, not the live request
        lane_b = 8'(mem.rdata >> {off, 3'b000});
        lane_h = 16'(mem.rdata >> {off[1], 4'b0000});
        ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & lane_b[7]}}, lane_b}
            : f3[1:0] == 2'b01 ? {{16{~f3[2] & lane_h[15]}}, lane_h} : mem.rdata;
        tmo = (TIMEOUT > 0) && (cnt + 32'd1 == 32'(TIMEOUT));
        state_nxt = state;
        err_nxt = 1'b0;
        rdata_nxt = '0;
        case (state)
            IDLE: if (req_valid) begin
                state_nxt = bad ? RESP : ISSUE;
                err_nxt = bad;
            end
            ISSUE: if (tmo) begin
                state_nxt = RESP;
                err_nxt = 1'b1;
            end else if (mem.gnt) begin
                state_nxt = mem.we ? RESP : WAIT;
            end
            WAIT: if (tmo) begin
                state_nxt = RESP;
                err_nxt = 1'b1;
            end else if (mem.rvalid) begin
                state_nxt = RESP;
                rdata_nxt = ext;
            end
            RESP: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            f3 <= '0;
            off <= '0;
            mem.we <= 1'b0;
            mem.addr <= '0;
            mem.be <= '0;
            mem.wdata <= '0;
            resp_err <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_nxt;
            cnt <= (state == ISSUE || state == WAIT) ? cnt + 32'd1 : '0;
            resp_err <= err_nxt;
            resp_rdata <= rdata_nxt;
            if (accept) begin
                f3 <= req_funct3;
                off <= req_addr[1:0];
                mem.we <= req_we;
                mem.addr <= {req_addr[ADDR_W-1:2], 2'b00};
                mem.be <= be_fmt;
                mem.wdata <= wdata_fmt;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb_lsu_mem_bridge: table-driven vectors with a response scoreboard, plus hand-written
// sequences for timeout, late read data, back-to-back requests and mid-access reset.
module tb_lsu_mem_bridge;
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          gd, rd;
        logic [3:0]  be;
        logic [31:0] maddr, mwdata, exp_rdata;
        logic        exp_err;
        int          lat, nreq;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    int          n_run = 0;
    int          n_fail = 0;
    exp_t        sbq[$];
    vec_t        vecs[15];
    lsu_mem_bridge_if #(.ADDR_W(32)) mem_if();
    lsu_mem_bridge #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem(mem_if.master)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", n, act, exp);
        end
    endtask
    // Drives one request, plays the memory (grant after gd cycles, rvalid rd cycles after that)
    task automatic run_vec(input string t, input vec_t v, input bit keep);
        exp_t e;
        int cyc, nreq, rv_at;
        bit done;
        req_we = v.we;
        req_funct3 = v.f3;
        req_addr = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        e.rdata = v.exp_rdata;
        e.err = v.exp_err;
        e.lat = v.lat;
        sbq.push_back(e);
        for (int i = 0; i < 20 && !req_ready; i++) step();
        chk({t, " ready"}, req_ready, 1);
        cyc = 0;
        nreq = 0;
        rv_at = -1;
        done = 0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            mem_if.gnt = 1'b0;
            mem_if.rvalid = cyc == rv_at;
            mem_if.rdata = cyc == rv_at ? v.rdata : ~v.rdata;
            if (mem_if.req) begin
                nreq++;
                if (nreq == 1) begin
                    chk({t, " mem_addr"}, mem_if.addr, v.maddr);
                    chk({t, " mem_be"}, {28'd0, mem_if.be}, {28'd0, v.be});
                    chk({t, " mem_we"}, {31'd0, mem_if.we}, {31'd0, v.we});
                    if (v.we) chk({t, " mem_wdata"}, mem_if.wdata, v.mwdata);
                end
                if (nreq - 1 == v.gd) begin
                    mem_if.gnt = 1'b1;
                    if (!v.we) rv_at = cyc + 1 + v.rd;
                end
            end
            if (resp_valid) begin
                done = 1;
                if (sbq.size() == 0) begin
                    chk({t, " unexpected_resp"}, 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk({t, " resp_rdata"}, resp_rdata, e.rdata);
                    chk({t, " resp_err"}, {31'd0, resp_err}, {31'd0, e.err});
                    chk({t, " latency"}, cyc, e.lat);
                end
            end
        end
        if (!done) chk({t, " resp_timeout"}, 0, 1);
        chk({t, " mem_req_cycles"}, nreq, v.nreq);
        if (!keep) req_valid = 1'b0;
        step();
        mem_if.gnt = 1'b0;
        mem_if.rvalid = 1'b0;
        chk({t, " resp_pulse"}, {31'd0, resp_valid}, 0);
        chk({t, " err_clear"}, {31'd0, resp_err}, 0);
        chk({t, " rdata_clear"}, resp_rdata, 0);
        chk({t, " idle_ready"}, {31'd0, req_ready}, 1);
        chk({t, " idle_req"}, {31'd0, mem_if.req}, 0);
    endtask
    task automatic chk_zero(input string t);
        chk({t, " mem_req"}, {31'd0, mem_if.req}, 0);
        chk({t, " mem_we"}, {31'd0, mem_if.we}, 0);
        chk({t, " mem_be"}, {28'd0, mem_if.be}, 0);
        chk({t, " mem_addr"}, mem_if.addr, 0);
        chk({t, " mem_wdata"}, mem_if.wdata, 0);
        chk({t, " resp_valid"}, {31'd0, resp_valid}, 0);
        chk({t, " resp_err"}, {31'd0, resp_err}, 0);
        chk({t, " resp_rdata"}, resp_rdata, 0);
        chk({t, " req_ready"}, {31'd0, req_ready}, 1);
    endtask
    initial begin
        bit seen;
        vec_t v;
        mem_if.gnt = 1'b0;
        mem_if.rvalid = 1'b0;
        mem_if.rdata = '0;
        //          we    f3    addr      wdata         rdata         gd   rd be     maddr     mwdata        exp_rdata     err  lat nreq
        vecs[0]  = '{1'b1, 3'd2, 32'h64,  32'h19,       32'h0,        0,   0, 4'hF, 32'h64,  32'h19,       32'h0,        1'b0, 2, 1};
        vecs[1]  = '{1'b0, 3'd0, 32'h63,  32'h0,        32'h80FF7F01, 0,   0, 4'h8, 32'h60,  32'h0,        32'hFFFFFF80, 1'b0, 3, 1};
        vecs[2]  = '{1'b0, 3'd4, 32'h63,  32'h0,        32'h80FF7F01, 0,   0, 4'h8, 32'h60,  32'h0,        32'h00000080, 1'b0, 3, 1};
        vecs[3]  = '{1'b0, 3'd1, 32'h62,  32'h0,        32'h80FF7F01, 0,   0, 4'hC, 32'h60,  32'h0,        32'hFFFF80FF, 1'b0, 3, 1};
        vecs[4]  = '{1'b1, 3'd1, 32'h22,  32'h1234ABCD, 32'h0,        0,   0, 4'hC, 32'h20,  32'hABCDABCD, 32'h0,        1'b0, 2, 1};
        vecs[5]  = '{1'b0, 3'd2, 32'h22,  32'h0,        32'h0,        0,   0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1, 0};
        vecs[6]  = '{1'b1, 3'd0, 32'h21,  32'h000000A5, 32'h0,        0,   0, 4'h2, 32'h20,  32'hA5A5A5A5, 32'h0,        1'b0, 2, 1};
        vecs[7]  = '{1'b0, 3'd5, 32'h60,  32'h0,        32'h80FF7F01, 0,   0, 4'h3, 32'h60,  32'h0,        32'h00007F01, 1'b0, 3, 1};
        vecs[8]  = '{1'b0, 3'd1, 32'h61,  32'h0,        32'h0,        0,   0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1, 0};
        vecs[9]  = '{1'b0, 3'd3, 32'h0,   32'h0,        32'h0,        0,   0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1, 0};
        vecs[10] = '{1'b1, 3'd4, 32'h0,   32'h0,        32'h0,        0,   0, 4'h0, 32'h0,   32'h0,        32'h0,        1'b1, 1, 0};
        vecs[11] = '{1'b0, 3'd2, 32'h44,  32'h0,        32'hCAFEF00D, 2,   3, 4'hF, 32'h44,  32'h0,        32'hCAFEF00D, 1'b0, 8, 3};
        vecs[12] = '{1'b0, 3'd0, 32'h61,  32'h0,        32'h80FF7F01, 1,   0, 4'h2, 32'h60,  32'h0,        32'h0000007F, 1'b0, 4, 2};
        vecs[13] = '{1'b1, 3'd2, 32'h8,   32'h11223344, 32'h0,        3,   0, 4'hF, 32'h8,   32'h11223344, 32'h0,        1'b0, 5, 4};
        vecs[14] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h12345678, 255, 0, 4'hF, 32'h100, 32'h0,        32'h0,        1'b1, 17, 16};
        step();
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        for (int i = 0; i < 15; i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b0);
        // read data arriving in IDLE after the timeout must not produce a response
        mem_if.rvalid = 1'b1;
        mem_if.rdata = 32'h5A5A5A5A;
        seen = 0;
        repeat (3) begin
            step();
            seen |= resp_valid | mem_if.req;
        end
        mem_if.rvalid = 1'b0;
        chk("late_rvalid", {31'd0, seen}, 0);
        v = '{1'b1, 3'd2, 32'h30, 32'h55, 32'h0, 0, 0, 4'hF, 32'h30, 32'h55, 32'h0, 1'b0, 2, 1};
        run_vec("b2b_sw", v, 1'b1);
        v = '{1'b0, 3'd2, 32'h30, 32'h0, 32'h12345678, 0, 0, 4'hF, 32'h30, 32'h0, 32'h12345678, 1'b0, 3, 1};
        run_vec("b2b_lw", v, 1'b0);
        req_we = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h40;
        req_valid = 1'b1;
        step();
        chk("rst_issue", {31'd0, mem_if.req}, 1);
        mem_if.gnt = 1'b1;
        step();
        mem_if.gnt = 1'b0;
        req_valid = 1'b0;
        chk("rst_wait_req", {31'd0, mem_if.req}, 0);
        chk("rst_wait_ready", {31'd0, req_ready}, 0);
        #2 reset = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        mem_if.rvalid = 1'b1;
        mem_if.rdata = 32'hDEADBEEF;
        seen = 0;
        repeat (2) begin
            step();
            seen |= resp_valid;
        end
        mem_if.rvalid = 1'b0;
        chk("rst_late_rvalid", {31'd0, seen}, 0);
        v = '{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1};
        run_vec("post_rst_lw", v, 1'b0);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
